// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch (I) and memory-stage (D) requesters.
// Round-robin on ties; outputs registered except the stall lines; a busy timer aborts hung transfers.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ireqF,
   input  logic [ADDR_WIDTH-1:0] iaddrF,
   output logic                  iackF,
   output logic [DATA_WIDTH-1:0] irdataF,
   input  logic                  dreqM,
   input  logic                  dweM,
   input  logic [ADDR_WIDTH-1:0] daddrM,
   input  logic [DATA_WIDTH-1:0] dwdataM,
   output logic                  dackM,
   output logic [DATA_WIDTH-1:0] drdataM,
   output logic                  stallFD,
   output logic                  stallM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  err
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

   state_t          state;
   logic            lastD;
   logic [TW-1:0]   timer;

   assign stallFD = ireqF & ~iackF;
   assign stallM  = dreqM & ~dackM;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         lastD     <= 1'b0;
         timer     <= '0;
         iackF     <= 1'b0;
         dackM     <= 1'b0;
         err       <= 1'b0;
         irdataF   <= '0;
         drdataM   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         // Acks and err only ever live for the single DONE cycle.
         iackF <= 1'b0;
         dackM <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (dreqM && (!ireqF || !lastD)) begin
                  state     <= DBUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= dweM;
                  mem_addr  <= daddrM;
                  mem_wdata <= dwdataM;
                  timer     <= '0;
                  lastD     <= 1'b1;
               end else if (ireqF) begin
                  state     <= IBUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= iaddrF;
                  mem_wdata <= '0;
                  timer     <= '0;
                  lastD     <= 1'b0;
               end
            end
            IBUSY, DBUSY: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if (state == IBUSY) begin
                     iackF   <= 1'b1;
                     irdataF <= mem_rdata;
                  end else begin
                     dackM <= 1'b1;
                     if (!mem_we) drdataM <= mem_rdata;
                  end
               end else if (timer == TLAST) begin
                  // Abort: acknowledge so the requester unblocks, but keep old read data.
                  state   <= DONE;
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  if (state == IBUSY) iackF <= 1'b1;
                  else                dackM <= 1'b1;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus tie, timeout and recovery sequences.
module tb_mem_arbiter;

   localparam logic [31:0] IA = 32'h0000_0100;
   localparam logic [31:0] DA = 32'h0001_0000;
   localparam logic [31:0] WD = 32'hDEAD_BEEF;
   localparam logic [31:0] P  = 32'h0050_0093;
   localparam logic [31:0] C  = 32'hCAFE_F00D;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireqF, dreqM, dweM, mem_ack;
   logic [31:0] iaddrF, daddrM, dwdataM, mem_rdata;
   logic        iackF, dackM, stallFD, stallM, mem_req, mem_we, err;
   logic [31:0] irdataF, drdataM, mem_addr, mem_wdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .ireqF(ireqF), .iaddrF(iaddrF), .iackF(iackF), .irdataF(irdataF),
      .dreqM(dreqM), .dweM(dweM), .daddrM(daddrM), .dwdataM(dwdataM),
      .dackM(dackM), .drdataM(drdataM),
      .stallFD(stallFD), .stallM(stallM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .err(err)
   );

   typedef struct {
      logic        rst, ireq, dreq, dwe, mack;
      logic [31:0] mrd;
      logic        iack, dack, mreq, mwe, err, sfd, sm;
      logic [31:0] addr, wd, ird, drd;
   } vec_t;

   vec_t vt[19];

   function automatic vec_t mk(input logic r, input logic ir, input logic dr, input logic dw,
                               input logic ma, input logic [31:0] md,
                               input logic ia, input logic da, input logic mq, input logic mw,
                               input logic er, input logic sf, input logic sm,
                               input logic [31:0] ad, input logic [31:0] w,
                               input logic [31:0] id, input logic [31:0] dd);
      vec_t v;
      v.rst = r; v.ireq = ir; v.dreq = dr; v.dwe = dw; v.mack = ma; v.mrd = md;
      v.iack = ia; v.dack = da; v.mreq = mq; v.mwe = mw; v.err = er; v.sfd = sf; v.sm = sm;
      v.addr = ad; v.wd = w; v.ird = id; v.drd = dd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Both sides request in the same cycle; expD says who should win.
   task automatic doTie(input logic expD, input logic [31:0] rdata, input int n);
      @(negedge clk);
      ireqF = 1'b1; dreqM = 1'b1; dweM = 1'b0;
      @(negedge clk);
      chk($sformatf("tie%0d_mreq", n), 32'(mem_req), 32'd1);
      chk($sformatf("tie%0d_addr", n), mem_addr, expD ? DA : IA);
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("tie%0d_iack", n), 32'(iackF), 32'(!expD));
      chk($sformatf("tie%0d_dack", n), 32'(dackM), 32'(expD));
      chk($sformatf("tie%0d_data", n), expD ? drdataM : irdataF, rdata);
      ireqF = 1'b0; dreqM = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int busyBad;
      rst = 1'b0; ireqF = 1'b0; dreqM = 1'b0; dweM = 1'b0; mem_ack = 1'b0;
      iaddrF = IA; daddrM = DA; dwdataM = WD; mem_rdata = '0;
      repeat (2) @(posedge clk);

      //          rst ir dr dw ma mrd            ia da mq mw er sf sm addr wd  ird drd
      vt[0]  = mk(0,  0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0);
      vt[1]  = mk(1,  1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 0, 0,   0,  0, 0);
      vt[2]  = mk(1,  1, 0, 0, 0, 32'h0,         0, 0, 1, 0, 0, 1, 0, IA,  0,  0, 0);
      vt[3]  = mk(1,  1, 0, 0, 0, 32'h0,         0, 0, 1, 0, 0, 1, 0, IA,  0,  0, 0);
      vt[4]  = mk(1,  1, 0, 0, 0, 32'h0,         0, 0, 1, 0, 0, 1, 0, IA,  0,  0, 0);
      vt[5]  = mk(1,  1, 0, 0, 1, P,             0, 0, 1, 0, 0, 1, 0, IA,  0,  0, 0);
      vt[6]  = mk(1,  1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 0, IA,  0,  P, 0);
      vt[7]  = mk(1,  0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0, IA,  0,  P, 0);
      vt[8]  = mk(1,  0, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1, IA,  0,  P, 0);
      vt[9]  = mk(1,  0, 1, 1, 1, 32'h12345678,  0, 0, 1, 1, 0, 0, 1, DA,  WD, P, 0);
      vt[10] = mk(1,  0, 0, 0, 0, 32'h0,         0, 1, 0, 1, 0, 0, 0, DA,  WD, P, 0);
      vt[11] = mk(1,  0, 1, 0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 1, DA,  WD, P, 0);
      vt[12] = mk(1,  0, 1, 0, 1, C,             0, 0, 1, 0, 0, 0, 1, DA,  WD, P, 0);
      vt[13] = mk(1,  0, 1, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 0, DA,  WD, P, C);
      vt[14] = mk(1,  0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1, DA,  WD, P, C);
      vt[15] = mk(1,  0, 1, 0, 0, 32'h0,         0, 0, 1, 0, 0, 0, 1, DA,  WD, P, C);
      vt[16] = mk(0,  0, 1, 0, 0, 32'h0,         0, 0, 1, 0, 0, 0, 1, DA,  WD, P, C);
      vt[17] = mk(1,  0, 0, 0, 1, 32'h11111111,  0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0);
      vt[18] = mk(1,  0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0);

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         rst = vt[i].rst; ireqF = vt[i].ireq; dreqM = vt[i].dreq; dweM = vt[i].dwe;
         mem_ack = vt[i].mack; mem_rdata = vt[i].mrd;
         #1;
         chk($sformatf("row%0d_iack", i),  32'(iackF),   32'(vt[i].iack));
         chk($sformatf("row%0d_dack", i),  32'(dackM),   32'(vt[i].dack));
         chk($sformatf("row%0d_mreq", i),  32'(mem_req), 32'(vt[i].mreq));
         chk($sformatf("row%0d_mwe", i),   32'(mem_we),  32'(vt[i].mwe));
         chk($sformatf("row%0d_err", i),   32'(err),     32'(vt[i].err));
         chk($sformatf("row%0d_sfd", i),   32'(stallFD), 32'(vt[i].sfd));
         chk($sformatf("row%0d_sm", i),    32'(stallM),  32'(vt[i].sm));
         chk($sformatf("row%0d_addr", i),  mem_addr,     vt[i].addr);
         chk($sformatf("row%0d_wdata", i), mem_wdata,    vt[i].wd);
         chk($sformatf("row%0d_ird", i),   irdataF,      vt[i].ird);
         chk($sformatf("row%0d_drd", i),   drdataM,      vt[i].drd);
      end
      mem_ack = 1'b0;

      // Reset left lastD = I, so ties alternate D, I, D, I.
      doTie(1'b1, 32'hD0D0_0001, 0);
      doTie(1'b0, 32'h1010_0002, 1);
      doTie(1'b1, 32'hD0D0_0003, 2);
      doTie(1'b0, 32'h1010_0004, 3);

      // Hung memory: abort 16 cycles after the grant edge.
      @(negedge clk);
      ireqF = 1'b1;
      busyBad = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (err !== 1'b0 || iackF !== 1'b0 || mem_req !== 1'b1) busyBad++;
      end
      chk("to_busy_cycles_bad", 32'(busyBad), 32'd0);
      @(negedge clk);
      chk("to_err",    32'(err),     32'd1);
      chk("to_iack",   32'(iackF),   32'd1);
      chk("to_mreq",   32'(mem_req), 32'd0);
      chk("to_irdata", irdataF,      32'h1010_0004);
      ireqF = 1'b0;
      @(negedge clk);
      chk("to_err_drop",  32'(err),   32'd0);
      chk("to_iack_drop", 32'(iackF), 32'd0);

      // Normal D read after the abort.
      dreqM = 1'b1; dweM = 1'b0;
      @(negedge clk);
      chk("post_mreq", 32'(mem_req), 32'd1);
      chk("post_addr", mem_addr,     DA);
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_ack = 1'b0; dreqM = 1'b0;
      chk("post_dack", 32'(dackM), 32'd1);
      chk("post_err",  32'(err),   32'd0);
      chk("post_drd",  drdataM,    32'h5555_AAAA);
      @(negedge clk);
      chk("post_dack_drop", 32'(dackM), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
